// File: rtl/colour_decode.sv
// colour_decode: maps a 24-bit RGB word to a 3-bit palette index.
// Results are held in a 2-entry {colour, match} FIFO with valid/ready
// handshakes on both sides. A saturating counter tracks how many
// accepted words did not match the palette.
// Optional feature macro: NEAREST_MATCH_EN -- decode each channel by its
// MSB instead of requiring an exact palette value (every word matches).
module colour_decode #(
    parameter int MISS_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [23:0]           rgb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            colour,
    output logic                  match,
    output logic [MISS_CNT_W-1:0] miss_count
);

    logic [2:0] dec_colour;
    logic       dec_match;

    logic [3:0] slot [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic [3:0] head;

`ifdef NEAREST_MATCH_EN
    // Nearest palette entry: each channel's MSB selects its index bit.
    always_comb begin
        dec_colour = {rgb[23], rgb[15], rgb[7]};
        dec_match  = 1'b1;
    end
`else
    // Exact palette lookup; anything else decodes to index 0, no match.
    always_comb begin
        dec_colour = '0;
        dec_match  = 1'b0;
        case (rgb)
            24'h000000: begin dec_colour = 3'd0; dec_match = 1'b1; end
            24'h0000FF: begin dec_colour = 3'd1; dec_match = 1'b1; end
            24'h00FF00: begin dec_colour = 3'd2; dec_match = 1'b1; end
            24'h00FFFF: begin dec_colour = 3'd3; dec_match = 1'b1; end
            24'hFF0000: begin dec_colour = 3'd4; dec_match = 1'b1; end
            24'hFF00FF: begin dec_colour = 3'd5; dec_match = 1'b1; end
            24'hFFFF00: begin dec_colour = 3'd6; dec_match = 1'b1; end
            24'hFFFFFF: begin dec_colour = 3'd7; dec_match = 1'b1; end
            default:    begin dec_colour = '0;   dec_match = 1'b0; end
        endcase
    end
`endif

    // Handshake qualifiers; occupancy never exceeds 2, so bit 1 means full.
    always_comb begin
        in_ready  = ~count[1] & ~rst;
        out_valid = (count != 2'd0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; push is already blocked during reset by in_ready.
    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= {dec_colour, dec_match};
    end

    // Saturating count of accepted words that missed the palette.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count <= '0;
        end else if (push && !dec_match && (miss_count != '1)) begin
            miss_count <= miss_count + 1'b1;
        end
    end

    // Present the oldest entry, forced to zero when nothing is held.
    always_comb begin
        head = slot[rd_ptr];
        if (out_valid) begin
            colour = head[3:1];
            match  = head[0];
        end else begin
            colour = '0;
            match  = 1'b0;
        end
    end

endmodule

// File: tb/tb_colour_decode.sv
// Self-checking bench for colour_decode: directed vector table, stall,
// reset and saturation sequences, then randomized traffic against a
// queue-based reference model.
module tb_colour_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] rgb;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  colour;
    logic        match;
    logic [7:0]  miss_count;

    logic        in_valid2;
    logic        in_ready2;
    logic [23:0] rgb2;
    logic        out_valid2;
    logic        out_ready2;
    logic [2:0]  colour2;
    logic        match2;
    logic [1:0]  miss_count2;

    always #5 clk = ~clk;

    colour_decode #(.MISS_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .rgb(rgb),
        .out_valid(out_valid), .out_ready(out_ready),
        .colour(colour), .match(match), .miss_count(miss_count)
    );

    colour_decode #(.MISS_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .rgb(rgb2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .colour(colour2), .match(match2), .miss_count(miss_count2)
    );

    typedef struct {
        logic [23:0] rgb;
        int          colour;
        int          match;
        int          miss;
    } vec_t;

    vec_t vecs [10];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Palette value of an index: each index bit turns its channel fully on.
    function automatic logic [23:0] pal_rgb(input int idx);
        int v;
        v = ((idx >> 2) & 1) * 32'hFF0000 + ((idx >> 1) & 1) * 32'h00FF00 + (idx & 1) * 32'h0000FF;
        return v[23:0];
    endfunction

    // Reference decode computed from the palette rules.
    task automatic ref_decode(input logic [23:0] v, output int c, output int m);
`ifdef NEAREST_MATCH_EN
        c = int'(v[23]) * 4 + int'(v[15]) * 2 + int'(v[7]);
        m = 1;
`else
        c = 0;
        m = 0;
        for (int i = 0; i < 8; i++) begin
            if (v == pal_rgb(i)) begin
                c = i;
                m = 1;
            end
        end
`endif
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        rgb        = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        rgb2       = '0;
        #1;
        check("rst.in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    int q_c [$];
    int q_m [$];
    int miss_m;
    int ec, em;
    bit exp_valid, acc_in, acc_out;

    initial begin
        // Directed vectors: all palette values, then two misses.
        for (int i = 0; i < 8; i++) vecs[i] = '{pal_rgb(i), i, 1, 0};
`ifdef NEAREST_MATCH_EN
        vecs[8] = '{24'h123456, 0, 1, 0};
        vecs[9] = '{24'h80007F, 4, 1, 0};
`else
        vecs[8] = '{24'h123456, 0, 0, 1};
        vecs[9] = '{24'h80007F, 0, 0, 2};
`endif

        do_reset();
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.in_ready", int'(in_ready), 1);
        check("reset.miss_count", int'(miss_count), 0);
        check("reset.colour", int'(colour), 0);
        check("reset.match", int'(match), 0);

        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            rgb       = vecs[i].rgb;
            out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d.in_ready", i), int'(in_ready), 1);
            @(posedge clk); #1;
            check($sformatf("vec%0d.out_valid", i), int'(out_valid), 1);
            check($sformatf("vec%0d.colour", i), int'(colour), vecs[i].colour);
            check($sformatf("vec%0d.match", i), int'(match), vecs[i].match);
            check($sformatf("vec%0d.miss", i), int'(miss_count), vecs[i].miss);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain.out_valid", int'(out_valid), 0);
        check("drain.colour", int'(colour), 0);
        check("drain.match", int'(match), 0);

        // Stall: two words fill the FIFO, third is refused until a pop.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rgb       = 24'h00FF00;
        @(posedge clk); #1;
        check("stall.first_colour", int'(colour), 2);
        rgb = 24'hFF0000;
        #1;
        check("stall.second_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rgb = 24'hFFFFFF;
        #1;
        check("stall.full_ready", int'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stall.hold_valid", int'(out_valid), 1);
            check("stall.hold_colour", int'(colour), 2);
            check("stall.hold_match", int'(match), 1);
            check("stall.hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall.pop1_colour", int'(colour), 4);
        check("stall.pop1_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall.pop2_colour", int'(colour), 7);
        check("stall.pop2_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        check("stall.empty_valid", int'(out_valid), 0);

        // Reset mid-stream discards queued results and the offered word.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rgb       = 24'h0000FF;
        @(posedge clk); #1;
        rgb = 24'h123456;
        @(posedge clk); #1;
        check("rstmid.full_ready", int'(in_ready), 0);
        rst = 1'b1;
        rgb = 24'hFF00FF;
        #1;
        check("rstmid.ready_in_rst", int'(in_ready), 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstmid.out_valid", int'(out_valid), 0);
        check("rstmid.miss", int'(miss_count), 0);
        check("rstmid.in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rstmid.no_ghost", int'(out_valid), 0);
        end
        in_valid = 1'b1;
        rgb      = 24'hFFFF00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid.new_colour", int'(colour), 6);
        check("rstmid.new_valid", int'(out_valid), 1);

        // Narrow counter saturation on the 2-bit instance.
        do_reset();
        in_valid2 = 1'b1;
        rgb2      = 24'h123456;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
`ifdef NEAREST_MATCH_EN
            check($sformatf("sat.miss%0d", k), int'(miss_count2), 0);
`else
            check($sformatf("sat.miss%0d", k), int'(miss_count2), (k + 1 > 3) ? 3 : k + 1);
`endif
        end
        in_valid2 = 1'b0;

        // Randomized traffic against the queue model.
        do_reset();
        q_c.delete();
        q_m.delete();
        miss_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            rgb       = ($urandom_range(0, 1) == 1) ? pal_rgb(int'($urandom_range(0, 7))) : 24'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_valid = (q_c.size() != 0);
            check("rand.out_valid", int'(out_valid), int'(exp_valid));
            check("rand.colour", int'(colour), exp_valid ? q_c[0] : 0);
            check("rand.match", int'(match), exp_valid ? q_m[0] : 0);
            check("rand.in_ready", int'(in_ready), (!rst && q_c.size() < 2) ? 1 : 0);
            check("rand.miss", int'(miss_count), miss_m);
            acc_in  = in_valid && !rst && (q_c.size() < 2);
            acc_out = exp_valid && out_ready && !rst;
            ref_decode(rgb, ec, em);
            @(posedge clk); #1;
            if (rst) begin
                q_c.delete();
                q_m.delete();
                miss_m = 0;
            end else begin
                if (acc_out) begin
                    void'(q_c.pop_front());
                    void'(q_m.pop_front());
                end
                if (acc_in) begin
                    q_c.push_back(ec);
                    q_m.push_back(em);
                    if (em == 0 && miss_m < 255) miss_m++;
                end
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/colour_decode.md
COLOUR_DECODE -- requirements
Module: colour_decode

Interface
REQ-001 The block SHALL have parameter MISS_CNT_W, default 8, setting the width of the miss counter in bits.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid  input  1  rgb holds a word to decode.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-006 The block SHALL have port rgb  input  24  pixel colour {R[23:16], G[15:8], B[7:0]}.
REQ-007 The block SHALL have port out_valid  output  1  colour/match hold a decoded result.
REQ-008 The block SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-009 The block SHALL have port colour  output  3  decoded colour index.
REQ-010 The block SHALL have port match  output  1  input was a legal palette value.
REQ-011 The block SHALL have port miss_count  output  MISS_CNT_W  count of accepted non-matching words.

Function
REQ-012 The block SHALL use palette index->rgb: 0=000000, 1=0000FF, 2=00FF00, 3=00FFFF, 4=FF0000, 5=FF00FF, 6=FFFF00, 7=FFFFFF (index bit2=R, bit1=G, bit0=B).
REQ-013 The block SHALL accept a word on a rising edge where in_valid=1 and in_ready=1; otherwise no input transfer occurs.
REQ-014 The block SHALL complete an output transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-015 The block SHALL hold results in a 2-entry FIFO of {colour, match}; in_ready = (occupancy < 2), driven from registered state only.
REQ-016 The block SHALL have latency 1: a word accepted at edge N appears on colour/match with out_valid=1 after edge N when the FIFO was empty.
REQ-017 The block SHALL present the oldest entry on colour/match; results leave in acceptance order.
REQ-018 The block SHALL keep colour, match and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 The block SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 and present the new entry.
REQ-020 The block SHALL, when full (occupancy 2), deassert in_ready; a pop that cycle frees the slot for the next cycle only.
REQ-021 The block SHALL, for an exact palette match, output that index with match=1.
REQ-022 The block SHALL, without NEAREST_MATCH_EN, output colour=0 and match=0 for any non-palette word.
REQ-023 The block SHALL increment miss_count on every accepted word with match=0, saturating at all-ones.
REQ-024 The block SHALL drive colour=0 and match=0 while out_valid=0.

Reset
REQ-025 The block SHALL, when rst=1 at a rising edge, empty the FIFO, set out_valid=0, colour=0, match=0, miss_count=0; in_ready=1 from the following cycle.
REQ-026 The block SHALL discard any input offered or FIFO contents held during the reset edge, including mid-stream.
REQ-027 The block SHALL hold in_ready=0 in any cycle where rst=1.

Configuration
REQ-028 The block SHALL, with macro NEAREST_MATCH_EN defined, decode each channel by its MSB (R[23], G[15], B[7]) into index bits 2/1/0, always setting match=1 and never incrementing miss_count.
REQ-029 The block SHALL, with NEAREST_MATCH_EN undefined, use exact 24-bit palette comparison per REQ-021/REQ-022.

Verification
REQ-030 Bench SHALL cover: after reset, stream all 8 palette values with out_ready=1 -> colour 0..7, match=1, each 1 cycle after acceptance, miss_count=0.
REQ-031 Bench SHALL cover: out_ready=0, offer 00FF00, FF0000, FFFFFF -> first two accepted, in_ready=0 on third; release out_ready -> outputs 2, 4, 7 in order, values stable while stalled.
REQ-032 Bench SHALL cover: exact mode, offer 123456 -> colour=0, match=0, miss_count=1; with NEAREST_MATCH_EN, 80007F -> colour=4, match=1, miss_count=0.
REQ-033 Bench SHALL cover: MISS_CNT_W=2, five accepted misses -> miss_count goes 1, 2, 3, 3, 3.
REQ-034 Bench SHALL cover: two entries queued, rst=1 for one edge -> out_valid=0, miss_count=0, in_ready=1 next cycle; queued results never appear.
